// File: rtl/display_pkg.sv
// Shared types, constants and helpers for the 8-digit 7-segment display scanner.
package display_pkg;

  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned DIGIT_W    = 3;
  localparam int unsigned SEG_W      = 8;

  localparam logic [SEG_W-1:0]      SEG_BLANK   = 8'hFF;
  localparam logic [NUM_DIGITS-1:0] ANODES_OFF  = 8'hFF;

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_BLANK = 2'd1,
    S_DRIVE = 2'd2
  } state_e;

  // Active-low one-hot anode vector selecting digit idx.
  function automatic logic [NUM_DIGITS-1:0] digit_onehot_n(input logic [DIGIT_W-1:0] idx);
    return ~(NUM_DIGITS'(1) << idx);
  endfunction

endpackage

// File: rtl/display_scanner_if.sv
// Game-core to display-scanner bus: frame pattern plus end-of-game flag.
interface display_scanner_if;
  logic [63:0] game_display;
  logic        game_eog;

  modport master (output game_display, output game_eog);
  modport slave  (input  game_display, input  game_eog);
endinterface

// File: rtl/slot_timer.sv
// Loadable down-counter; tc_c flags a zero count, tc_next_c flags that the next count is zero.
module slot_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc_c,
  output logic         tc_next_c
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  assign tc_c      = (cnt_q == '0);
  assign tc_next_c = (cnt_d == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/display_scanner.sv
// Time-multiplexed 8-digit common-anode display driver with per-frame snapshot,
// inter-digit dead-time and end-of-game blink.
module display_scanner
  import display_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLANK_CYCLES = 16,
  parameter int unsigned BLINK_FRAMES = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  display_scanner_if.slave      bus,
  input  logic                  disp_en,
  output logic [SEG_W-1:0]      seg_n,
  output logic [NUM_DIGITS-1:0] an_n,
  output logic                  frame_done
);

  localparam int unsigned CNT_W        = $clog2(SCAN_DIV);
  localparam int unsigned DRIVE_CYCLES = SCAN_DIV - BLANK_CYCLES;
  localparam int unsigned BLINK_W      = $clog2(BLINK_FRAMES + 1);

  state_e                       state_q, state_d;
  logic [DIGIT_W-1:0]           digit_q, digit_d;
  logic [NUM_DIGITS*SEG_W-1:0]  shadow_q, shadow_d;
  logic [BLINK_W-1:0]           blink_cnt_q, blink_cnt_d;
  logic                         blink_off_q, blink_off_d;
  logic [SEG_W-1:0]             seg_n_q, seg_n_d;
  logic [NUM_DIGITS-1:0]        an_n_q, an_n_d;
  logic                         frame_done_q, frame_done_d;

  logic                         slot_load;
  logic [CNT_W-1:0]             slot_load_val;
  logic                         slot_tc_c, slot_tc_next_c;

  slot_timer #(.W(CNT_W)) u_slot_timer (
    .clk       (clk),
    .rst       (rst),
    .load      (slot_load),
    .load_val  (slot_load_val),
    .tc_c      (slot_tc_c),
    .tc_next_c (slot_tc_next_c)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_LOAD;
    else      state_q <= state_d;
  end

  // Next state, snapshot/blink datapath and slot timer reload on every state entry.
  always_comb begin
    state_d       = state_q;
    digit_d       = digit_q;
    shadow_d      = shadow_q;
    blink_cnt_d   = blink_cnt_q;
    blink_off_d   = blink_off_q;
    slot_load     = 1'b0;
    slot_load_val = '0;
    unique case (state_q)
      S_LOAD: begin
        shadow_d = bus.game_display;
        digit_d  = '0;
        state_d  = S_BLANK;
        if (!bus.game_eog) begin
          blink_cnt_d = '0;
          blink_off_d = 1'b0;
        end else if (blink_cnt_q == BLINK_W'(BLINK_FRAMES - 1)) begin
          blink_cnt_d = '0;
          blink_off_d = ~blink_off_q;
        end else begin
          blink_cnt_d = blink_cnt_q + BLINK_W'(1);
        end
      end
      S_BLANK: begin
        if (slot_tc_c) state_d = S_DRIVE;
      end
      S_DRIVE: begin
        if (slot_tc_c) begin
          if (digit_q == DIGIT_W'(NUM_DIGITS - 1)) begin
            state_d = S_LOAD;
          end else begin
            digit_d = digit_q + DIGIT_W'(1);
            state_d = S_BLANK;
          end
        end
      end
      default: state_d = S_LOAD;
    endcase
    if (state_d != state_q) begin
      slot_load = 1'b1;
      if (state_d == S_BLANK)      slot_load_val = CNT_W'(BLANK_CYCLES - 1);
      else if (state_d == S_DRIVE) slot_load_val = CNT_W'(DRIVE_CYCLES - 1);
    end
  end

  // Pin values for the upcoming state, so the registered outputs track state_q.
  always_comb begin
    an_n_d       = ANODES_OFF;
    seg_n_d      = SEG_BLANK;
    frame_done_d = 1'b0;
    if (state_d == S_DRIVE) begin
      seg_n_d      = ~shadow_q[{digit_d, 3'b000} +: SEG_W];
      frame_done_d = (digit_d == DIGIT_W'(NUM_DIGITS - 1)) && slot_tc_next_c;
      if (disp_en && !blink_off_d) an_n_d = digit_onehot_n(digit_d);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      digit_q      <= '0;
      shadow_q     <= '0;
      blink_cnt_q  <= '0;
      blink_off_q  <= 1'b0;
      seg_n_q      <= SEG_BLANK;
      an_n_q       <= ANODES_OFF;
      frame_done_q <= 1'b0;
    end else begin
      digit_q      <= digit_d;
      shadow_q     <= shadow_d;
      blink_cnt_q  <= blink_cnt_d;
      blink_off_q  <= blink_off_d;
      seg_n_q      <= seg_n_d;
      an_n_q       <= an_n_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg_n      = seg_n_q;
  assign an_n       = an_n_q;
  assign frame_done = frame_done_q;

endmodule
